// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the multi-cycle shift sequencer: op and FSM encodings,
// counter width and the amount-to-count clamp.
package shift_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    SHIFT_OP_SLL  = 2'b00,
    SHIFT_OP_SRL  = 2'b01,
    SHIFT_OP_SRA  = 2'b10,
    SHIFT_OP_PASS = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // Any amount >= 32 behaves exactly like 32, so the count never needs more than 6 bits.
  function automatic logic [CNT_W-1:0] clamp_amt(input logic [31:0] amt, input shift_op_e op);
    if (op == SHIFT_OP_PASS) return '0;
    if (amt[31:5] != 27'd0) return CNT_W'(32);
    return {1'b0, amt[4:0]};
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_step_unit.sv
// Narrow shift stage: shifts acc by k (0..STEP) with the fill selected by op.
// Built as a (STEP+1)-way mux of constant shifts rather than a full barrel shifter.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  shift_op_e         op,
  input  logic [31:0]       acc,
  input  logic [CNT_W-1:0]  k,
  output logic [31:0]       res
);

  always_comb begin
    res = acc;
    for (int i = 1; i <= STEP; i++) begin
      if (k == CNT_W'(i)) begin
        case (op)
          SHIFT_OP_SLL: res = acc << i;
          SHIFT_OP_SRL: res = acc >> i;
          SHIFT_OP_SRA: res = $unsigned($signed(acc) >>> i);
          default:      res = acc;
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer with valid/ready on both sides.
// Optional macro SHIFT_FAST_PATH_EN resolves clamped (>=32) shifts in a single step.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_amt,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        busy
);

  localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STEP);

  state_e           state_q, state_d;
  shift_op_e        op_q, op_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      out_res_q, out_res_d;
  logic             out_valid_q, out_valid_d;

  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] cnt_after;
  logic [CNT_W-1:0] accept_cnt;
  logic [31:0]      step_res;

  assign k          = (cnt_q > STEP_CNT) ? STEP_CNT : cnt_q;
  assign cnt_after  = cnt_q - k;
  assign accept_cnt = clamp_amt(in_amt, shift_op_e'(in_op));

  shift_step_unit #(.STEP(STEP)) u_step (
    .op  (op_q),
    .acc (acc_q),
    .k   (k),
    .res (step_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= SHIFT_OP_PASS;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_res_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_res_q   <= out_res_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_res_d   = out_res_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = shift_op_e'(in_op);
          acc_d   = in_data;
          cnt_d   = accept_cnt;
          state_d = S_SHIFT;
`ifdef SHIFT_FAST_PATH_EN
          // Preload the final value so the next edge completes; cnt==0 already needs one edge.
          if (accept_cnt == CNT_W'(32)) begin
            acc_d = (op_d == SHIFT_OP_SRA && in_data[31]) ? '1 : '0;
            cnt_d = '0;
          end
`endif
        end
      end
      S_SHIFT: begin
        acc_d = step_res;
        cnt_d = cnt_after;
        if (cnt_after == '0) begin
          state_d     = S_DONE;
          out_res_d   = step_res;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = out_valid_q;
    out_res   = out_res_q;
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: STEP=4 main instance plus a STEP=32 instance.
module tb_shift_seq_ctrl;

`ifdef SHIFT_FAST_PATH_EN
  localparam int LAT32 = 1;
`else
  localparam int LAT32 = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  in_op;
  logic [31:0] in_amt, in_data, out_res;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [1:0]  s_in_op;
  logic [31:0] s_in_amt, s_in_data, s_out_res;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_amt(in_amt), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .busy(busy)
  );

  shift_seq_ctrl #(.STEP(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
    .in_amt(s_in_amt), .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_res(s_out_res), .busy(s_busy)
  );

  // Issue one request, then count edges after the accept edge until out_valid (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] amt, input logic [31:0] data,
                        output logic [31:0] res, output int lat);
    in_op = op; in_amt = amt; in_data = data; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_res;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_res !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_out_res got %h want 00000000", out_res); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sll();
    logic [31:0] r; int l;
    run_op(2'b00, 32'd5, 32'h0000_0001, r, l);
    n_cmp++; if (r !== 32'h0000_0020) begin n_fail++; $display("[TB] FAIL sll5_res got %h want 00000020", r); end
    n_cmp++; if (l != 2) begin n_fail++; $display("[TB] FAIL sll5_lat got %0d want 2", l); end
    ack();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sll5_drop got %b want 0", out_valid); end
    n_cmp++; if (out_res !== 32'h0000_0020) begin n_fail++; $display("[TB] FAIL sll5_retain got %h want 00000020", out_res); end
  endtask

  task automatic test_shift31();
    logic [31:0] r; int l;
    run_op(2'b10, 32'd31, 32'h8000_0000, r, l);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL sra31_res got %h want ffffffff", r); end
    n_cmp++; if (l != 8) begin n_fail++; $display("[TB] FAIL sra31_lat got %0d want 8", l); end
    ack();
    run_op(2'b01, 32'd31, 32'h8000_0000, r, l);
    n_cmp++; if (r !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL srl31_res got %h want 00000001", r); end
    n_cmp++; if (l != 8) begin n_fail++; $display("[TB] FAIL srl31_lat got %0d want 8", l); end
    ack();
  endtask

  task automatic test_clamp();
    logic [31:0] r; int l;
    run_op(2'b01, 32'h0000_0020, 32'hFFFF_FFFF, r, l);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL srl32_res got %h want 00000000", r); end
    n_cmp++; if (l != LAT32) begin n_fail++; $display("[TB] FAIL srl32_lat got %0d want %0d", l, LAT32); end
    ack();
    run_op(2'b10, 32'h1000_0000, 32'h8000_0001, r, l);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL sra_big_res got %h want ffffffff", r); end
    n_cmp++; if (l != LAT32) begin n_fail++; $display("[TB] FAIL sra_big_lat got %0d want %0d", l, LAT32); end
    ack();
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL sll_big_res got %h want 00000000", r); end
    ack();
    run_op(2'b10, 32'h0000_0040, 32'h7FFF_FFFF, r, l);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL sra_pos_big_res got %h want 00000000", r); end
    ack();
  endtask

  task automatic test_pass_zero();
    logic [31:0] r; int l;
    run_op(2'b11, 32'd7, 32'hDEAD_BEEF, r, l);
    n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL pass_res got %h want deadbeef", r); end
    n_cmp++; if (l != 1) begin n_fail++; $display("[TB] FAIL pass_lat got %0d want 1", l); end
    ack();
    run_op(2'b00, 32'd0, 32'h0000_1234, r, l);
    n_cmp++; if (r !== 32'h0000_1234) begin n_fail++; $display("[TB] FAIL amt0_res got %h want 00001234", r); end
    n_cmp++; if (l != 1) begin n_fail++; $display("[TB] FAIL amt0_lat got %0d want 1", l); end
    ack();
  endtask

  task automatic test_backpressure();
    logic [31:0] r; int l;
    run_op(2'b00, 32'd4, 32'h0000_0003, r, l);
    n_cmp++; if (r !== 32'h0000_0030) begin n_fail++; $display("[TB] FAIL bp_res got %h want 00000030", r); end
    in_op = 2'b01; in_amt = 32'd8; in_data = 32'h0000_0100; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid[%0d] got %b want 1", c, out_valid); end
      n_cmp++; if (out_res !== 32'h0000_0030) begin n_fail++; $display("[TB] FAIL bp_hold[%0d] got %h want 00000030", c, out_res); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready[%0d] got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 0;
    while (out_valid !== 1'b1 && l < 64) begin @(posedge clk); #1; l++; end
    n_cmp++; if (out_res !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL bp_next_res got %h want 00000001", out_res); end
    n_cmp++; if (l != 2) begin n_fail++; $display("[TB] FAIL bp_next_lat got %0d want 2", l); end
    ack();
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] r; int l; int seen;
    in_op = 2'b10; in_amt = 32'd31; in_data = 32'h8000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_busy got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rst got busy=%b ready=%b want 0/1", busy, in_ready); end
    n_cmp++; if (out_valid !== 1'b0 || out_res !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_rst_out got %b/%h want 0/00000000", out_valid, out_res); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("[TB] FAIL mid_ghost got %0d active cycles want 0", seen); end
    run_op(2'b00, 32'd1, 32'h0000_0003, r, l);
    n_cmp++; if (r !== 32'h0000_0006) begin n_fail++; $display("[TB] FAIL post_rst_res got %h want 00000006", r); end
    n_cmp++; if (l != 1) begin n_fail++; $display("[TB] FAIL post_rst_lat got %0d want 1", l); end
    ack();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int l;
    run_op(2'b10, 32'd4, 32'hF000_0000, r, l);
    n_cmp++; if (r !== 32'hFF00_0000) begin n_fail++; $display("[TB] FAIL b2b_sra_res got %h want ff000000", r); end
    n_cmp++; if (l != 1) begin n_fail++; $display("[TB] FAIL b2b_sra_lat got %0d want 1", l); end
    ack();
    run_op(2'b00, 32'd31, 32'h0000_0001, r, l);
    n_cmp++; if (r !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL b2b_sll_res got %h want 80000000", r); end
    n_cmp++; if (l != 8) begin n_fail++; $display("[TB] FAIL b2b_sll_lat got %0d want 8", l); end
    ack();
    run_op(2'b01, 32'd6, 32'h8765_4321, r, l);
    n_cmp++; if (r !== 32'h021D_950C) begin n_fail++; $display("[TB] FAIL b2b_srl_res got %h want 021d950c", r); end
    n_cmp++; if (l != 2) begin n_fail++; $display("[TB] FAIL b2b_srl_lat got %0d want 2", l); end
    ack();
  endtask

  task automatic test_step32();
    int l;
    s_in_op = 2'b00; s_in_amt = 32'd31; s_in_data = 32'h0000_0001; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    l = 0;
    while (s_out_valid !== 1'b1 && l < 64) begin @(posedge clk); #1; l++; end
    n_cmp++; if (s_out_res !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL step32_res got %h want 80000000", s_out_res); end
    n_cmp++; if (l != 1) begin n_fail++; $display("[TB] FAIL step32_lat got %0d want 1", l); end
    @(posedge clk); #1;
    s_in_op = 2'b10; s_in_amt = 32'd32; s_in_data = 32'h8000_0000; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    l = 0;
    while (s_out_valid !== 1'b1 && l < 64) begin @(posedge clk); #1; l++; end
    n_cmp++; if (s_out_res !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL step32_sra_res got %h want ffffffff", s_out_res); end
    n_cmp++; if (l != 1) begin n_fail++; $display("[TB] FAIL step32_sra_lat got %0d want 1", l); end
  endtask

  initial begin
    in_valid = 1'b0; in_op = 2'b00; in_amt = '0; in_data = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_op = 2'b00; s_in_amt = '0; s_in_data = '0; s_out_ready = 1'b1;
    test_reset();
    test_sll();
    test_shift31();
    test_clamp();
    test_pass_zero();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_step32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
